// File: rtl/vliw_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vliw_pipe_pkg
// Description : Shared constants and state encoding for the pipeline skid
//               register stage and its storage sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package vliw_pipe_pkg;

    // Default payload width used when a parent does not override WIDTH.
    localparam int C_DEFAULT_WIDTH = 32;

    // Occupancy of the stage. 2'b11 is never entered by design; if it is
    // reached through an upset, the stage falls back to ST_EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10,
        ST_BAD   = 2'b11
    } pipe_state_e;

endpackage : vliw_pipe_pkg
`default_nettype wire

// File: rtl/pipe_data_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_data_reg
// Description : WIDTH-bit payload register with load enable and synchronous
//               flush-to-RESET_VAL. Updates on the falling clock edge.
// Ports       : clk    - clock (falling edge active)
//               reset  - synchronous active-low reset, loads RESET_VAL
//               flush  - synchronous flush, loads RESET_VAL
//               en     - load d when high
//               d      - data in
//               q      - registered data out
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_data_reg
    import vliw_pipe_pkg::*;
#(
    parameter int               WIDTH     = C_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_data_q;
    logic [WIDTH-1:0] w_data_d;

    // Flush wins over a load on the same edge.
    always_comb begin
        w_data_d = r_data_q;
        if (flush) begin
            w_data_d = RESET_VAL;
        end else if (en) begin
            w_data_d = d;
        end
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            r_data_q <= RESET_VAL;
        end else begin
            r_data_q <= w_data_d;
        end
    end

    assign q = r_data_q;

endmodule : pipe_data_reg
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Valid/ready pipeline stage with a skid buffer. in_ready is a
//               registered decode of the occupancy state so there is no
//               combinational path from out_ready to in_ready. A stall counter
//               tracks cycles where the stage presents data that is refused.
//               All state updates on the falling clock edge.
// Ports       : clk       - clock (falling edge active)
//               reset     - synchronous active-low reset (priority over flush)
//               flush     - synchronous flush, empties the stage
//               in_valid  - upstream payload valid
//               in_ready  - stage can accept a payload this cycle
//               in_data   - upstream payload
//               out_valid - stage presents a valid payload
//               out_ready - downstream accepts the payload this cycle
//               out_data  - payload to downstream (main register)
//               stall_cnt - saturating count of out_valid & !out_ready edges
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
    import vliw_pipe_pkg::*;
#(
    parameter int               WIDTH     = C_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_state_e      r_state_q;
    pipe_state_e      w_state_d;
    logic             r_in_ready_q;
    logic             r_out_valid_q;
    logic [CNT_W-1:0] r_stall_q;
    logic [CNT_W-1:0] w_stall_d;

    logic             w_main_en;
    logic             w_main_from_skid;
    logic             w_skid_en;
    logic [WIDTH-1:0] w_main_din;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    // ------------------------------------------------------------------
    // Next-state and register-enable decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d        = r_state_q;
        w_main_en        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_en        = 1'b0;

        case (r_state_q)
            ST_EMPTY: begin
                if (in_valid) begin
                    w_main_en = 1'b1;
                    w_state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (in_valid && out_ready) begin
                    w_main_en = 1'b1;
                end else if (in_valid && !out_ready) begin
                    // Downstream refused while upstream pushed: park the
                    // new entry so in_ready could stay a pure state decode.
                    w_skid_en = 1'b1;
                    w_state_d = ST_SKID;
                end else if (!in_valid && out_ready) begin
                    w_state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                // in_ready is low here, so in_data is ignored.
                if (out_ready) begin
                    w_main_en        = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_d        = ST_FULL;
                end
            end
            default: begin
                w_state_d = ST_EMPTY;
            end
        endcase

        // Flush overrides every transition; the data registers handle
        // their own flush load.
        if (flush) begin
            w_state_d = ST_EMPTY;
        end
    end

    // ------------------------------------------------------------------
    // Stall counter: counts refused presentations, saturates, holds on flush
    // ------------------------------------------------------------------
    always_comb begin
        w_stall_d = r_stall_q;
        if (!flush && r_out_valid_q && !out_ready && (r_stall_q != '1)) begin
            w_stall_d = r_stall_q + C_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // State and registered handshake outputs. The outputs are decoded from
    // the next state so they always match the state register.
    // ------------------------------------------------------------------
    always_ff @(negedge clk) begin
        if (!reset) begin
            r_state_q     <= ST_EMPTY;
            r_in_ready_q  <= 1'b1;
            r_out_valid_q <= 1'b0;
            r_stall_q     <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_in_ready_q  <= (w_state_d == ST_EMPTY) || (w_state_d == ST_FULL);
            r_out_valid_q <= (w_state_d == ST_FULL)  || (w_state_d == ST_SKID);
            r_stall_q     <= w_stall_d;
        end
    end

    // ------------------------------------------------------------------
    // Payload storage
    // ------------------------------------------------------------------
    assign w_main_din = w_main_from_skid ? w_skid_q : in_data;

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main_reg (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .en    (w_main_en),
        .d     (w_main_din),
        .q     (w_main_q)
    );

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid_reg (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .en    (w_skid_en),
        .d     (in_data),
        .q     (w_skid_q)
    );

    assign in_ready  = r_in_ready_q;
    assign out_valid = r_out_valid_q;
    assign out_data  = w_main_q;
    assign stall_cnt = r_stall_q;

endmodule : pipe_skid_reg
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Directed and randomised checks of pipe_skid_reg. Three
//               instances (32-bit, 8-bit with 4-bit stall counter, 64-bit)
//               share clock and control inputs and have separate payloads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam logic [31:0] C_RV32 = 32'h5A5A_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush, in_valid, out_ready;

    logic [31:0] in_data32, out_data32;
    logic        in_ready32, out_valid32;
    logic [15:0] stall32;

    logic [7:0]  in_data8, out_data8;
    logic        in_ready8, out_valid8;
    logic [3:0]  stall8;

    logic [63:0] in_data64, out_data64;
    logic        in_ready64, out_valid64;
    logic [15:0] stall64;

    int n_vec = 0;
    int n_err = 0;

    pipe_skid_reg #(.WIDTH(32), .RESET_VAL(C_RV32), .CNT_W(16)) u_dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_data(in_data32),
        .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
        .stall_cnt(stall32)
    );

    pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(4)) u_dut8 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .stall_cnt(stall8)
    );

    pipe_skid_reg #(.WIDTH(64), .RESET_VAL(64'h0), .CNT_W(16)) u_dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_data(in_data64),
        .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64),
        .stall_cnt(stall64)
    );

    // Advance one active (falling) edge and settle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data32 = '0; in_data8 = '0; in_data64 = '0;
        tick();
        n_vec++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready32); end
        n_vec++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid32); end
        n_vec++; if (out_data32 !== C_RV32) begin n_err++; $display("FAIL reset_out_data: got %h want %h", out_data32, C_RV32); end
        n_vec++; if (stall32 !== 16'd0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", stall32); end
        n_vec++; if (out_data8 !== 8'h00) begin n_err++; $display("FAIL reset_out_data8: got %h want 00", out_data8); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data32 = 32'hA5A5_A5A5; out_ready = 1'b1;
        tick();
        n_vec++; if (out_valid32 !== 1'b1) begin n_err++; $display("FAIL single_out_valid: got %b want 1", out_valid32); end
        n_vec++; if (out_data32 !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL single_out_data: got %h want a5a5a5a5", out_data32); end
        n_vec++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL single_in_ready: got %b want 1", in_ready32); end
        in_valid = 1'b0;
        tick();
        n_vec++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", out_valid32); end
    endtask

    task automatic test_skid();
        in_valid = 1'b1; in_data32 = 32'h1; out_ready = 1'b1;
        tick();
        in_data32 = 32'h2; out_ready = 1'b0;
        tick();
        n_vec++; if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL skid_in_ready: got %b want 0", in_ready32); end
        n_vec++; if (out_data32 !== 32'h1) begin n_err++; $display("FAIL skid_out_data: got %h want 1", out_data32); end
        n_vec++; if (stall32 !== 16'd1) begin n_err++; $display("FAIL skid_stall: got %0d want 1", stall32); end
        in_data32 = 32'h3;
        tick();
        n_vec++; if (out_data32 !== 32'h1) begin n_err++; $display("FAIL skid_hold: got %h want 1", out_data32); end
        n_vec++; if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL skid_hold_ready: got %b want 0", in_ready32); end
        out_ready = 1'b1;
        tick();
        n_vec++; if (out_data32 !== 32'h2) begin n_err++; $display("FAIL skid_release: got %h want 2", out_data32); end
        n_vec++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL skid_release_ready: got %b want 1", in_ready32); end
        tick();
        n_vec++; if (out_data32 !== 32'h3) begin n_err++; $display("FAIL skid_third: got %h want 3", out_data32); end
        in_valid = 1'b0;
        tick();
        n_vec++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL skid_empty: got %b want 0", out_valid32); end
        n_vec++; if (stall32 !== 16'd2) begin n_err++; $display("FAIL skid_stall_end: got %0d want 2", stall32); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data32 = 32'h10; out_ready = 1'b0;
        tick();
        in_data32 = 32'h11;
        tick();
        n_vec++; if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL flush_pre_skid: got %b want 0", in_ready32); end
        flush = 1'b1; in_data32 = 32'h7;
        tick();
        flush = 1'b0;
        n_vec++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", out_valid32); end
        n_vec++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", in_ready32); end
        n_vec++; if (out_data32 !== C_RV32) begin n_err++; $display("FAIL flush_out_data: got %h want %h", out_data32, C_RV32); end
        n_vec++; if (stall32 !== 16'd3) begin n_err++; $display("FAIL flush_stall_hold: got %0d want 3", stall32); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_vec++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL flush_no_emit: got %b want 0", out_valid32); end
    endtask

    task automatic test_reset_priority();
        in_valid = 1'b1; in_data32 = 32'h20; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_vec++; if (stall32 !== 16'd5) begin n_err++; $display("FAIL prio_pre_stall: got %0d want 5", stall32); end
        n_vec++; if (out_valid32 !== 1'b1) begin n_err++; $display("FAIL prio_pre_full: got %b want 1", out_valid32); end
        reset = 1'b0; flush = 1'b1;
        tick();
        reset = 1'b1; flush = 1'b0;
        n_vec++; if (stall32 !== 16'd0) begin n_err++; $display("FAIL prio_stall: got %0d want 0", stall32); end
        n_vec++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL prio_out_valid: got %b want 0", out_valid32); end
        n_vec++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL prio_in_ready: got %b want 1", in_ready32); end
        out_ready = 1'b1;
        tick();
        n_vec++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL prio_discard: got %b want 0", out_valid32); end
    endtask

    task automatic test_stall_sat();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        in_valid = 1'b1; in_data8 = 8'h3C; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        n_vec++; if (stall8 !== 4'd10) begin n_err++; $display("FAIL sat_mid8: got %0d want 10", stall8); end
        n_vec++; if (stall32 !== 16'd10) begin n_err++; $display("FAIL sat_mid32: got %0d want 10", stall32); end
        repeat (10) tick();
        n_vec++; if (stall8 !== 4'hF) begin n_err++; $display("FAIL sat_cap8: got %h want f", stall8); end
        n_vec++; if (stall32 !== 16'd20) begin n_err++; $display("FAIL sat_cnt32: got %0d want 20", stall32); end
        n_vec++; if (out_data8 !== 8'h3C) begin n_err++; $display("FAIL sat_data8: got %h want 3c", out_data8); end
        n_vec++; if (out_valid8 !== 1'b1) begin n_err++; $display("FAIL sat_valid8: got %b want 1", out_valid8); end
    endtask

    task automatic test_random();
        logic [31:0] q32[$];
        logic [7:0]  q8[$];
        logic [63:0] q64[$];
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3004; i++) begin
            // The last few cycles only drain the stage.
            if (i < 3000) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            in_data32 = $urandom;
            in_data8  = 8'($urandom);
            in_data64 = {$urandom, $urandom};
            if (out_valid32 && out_ready) begin
                n_vec++;
                if (q32.size() == 0 || out_data32 !== q32[0]) begin
                    n_err++; $display("FAIL rand32 cycle %0d: got %h want %h", i, out_data32, (q32.size() != 0) ? q32[0] : 32'hx);
                end
                if (q32.size() != 0) void'(q32.pop_front());
            end
            if (out_valid8 && out_ready) begin
                n_vec++;
                if (q8.size() == 0 || out_data8 !== q8[0]) begin
                    n_err++; $display("FAIL rand8 cycle %0d: got %h want %h", i, out_data8, (q8.size() != 0) ? q8[0] : 8'hx);
                end
                if (q8.size() != 0) void'(q8.pop_front());
            end
            if (out_valid64 && out_ready) begin
                n_vec++;
                if (q64.size() == 0 || out_data64 !== q64[0]) begin
                    n_err++; $display("FAIL rand64 cycle %0d: got %h want %h", i, out_data64, (q64.size() != 0) ? q64[0] : 64'hx);
                end
                if (q64.size() != 0) void'(q64.pop_front());
            end
            if (in_valid && in_ready32) q32.push_back(in_data32);
            if (in_valid && in_ready8)  q8.push_back(in_data8);
            if (in_valid && in_ready64) q64.push_back(in_data64);
            tick();
        end
        n_vec++; if (q32.size() != 0) begin n_err++; $display("FAIL rand32_lost: got %0d left want 0", q32.size()); end
        n_vec++; if (q8.size() != 0) begin n_err++; $display("FAIL rand8_lost: got %0d left want 0", q8.size()); end
        n_vec++; if (q64.size() != 0) begin n_err++; $display("FAIL rand64_lost: got %0d left want 0", q64.size()); end
        n_vec++; if (out_valid64 !== 1'b0) begin n_err++; $display("FAIL rand_drained: got %b want 0", out_valid64); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_skid();
        test_flush();
        test_reset_priority();
        test_stall_sat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipe_skid_reg
`default_nettype wire
